// File: rtl/control_signals.sv
// Shared types for the multi-cycle sequencer: state encoding, fault codes and PC step.
package control_signals;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_FETCH_TO = 2'b01,
    FLT_ILLEGAL  = 2'b10,
    FLT_DATA_TO  = 2'b11
  } fault_code_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts consecutive un-acked bus wait cycles; expired pulses on the cycle the count hits MEM_TIMEOUT.
module bus_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam bit ENABLED          = (MEM_TIMEOUT > 0);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);
  // tick is only raised when no ack arrived, so an ack on the limit cycle never expires
  assign expired = ENABLED && tick && (cnt_inc == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !ENABLED) cnt_d = '0;
    else if (tick)         cnt_d = cnt_inc;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: owns PC and retire count, walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with req/ack memory handshakes.
module multicycle_sequencer
  import control_signals::*;
#(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      MEM_TIMEOUT  = 16,
  parameter int unsigned      CNT_W        = 32
) (
  input  logic             clk_in,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  output logic             ir_write,
  input  logic             dec_illegal,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_writes_rd,
  input  logic             dec_is_branch,
  input  logic             dec_is_jump,
  input  logic             branch_taken_in,
  input  logic [XLEN-1:0]  target_in,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             reg_write_en,
  output logic [XLEN-1:0]  pc_out,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] instret_out,
  output logic             halted_out,
  output logic [1:0]       fault_code_out
);

  seq_state_t  state_q, state_d;
  fault_code_t fault_q, fault_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic retire, redirect;
  logic to_tick, to_clear, to_expired;

  assign to_tick  = ((state_q == FETCH) && !imem_ack) || ((state_q == MEM) && !dmem_ack);
  assign to_clear = (state_d != state_q);

  bus_timeout_counter #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk_in  (clk_in),
    .reset   (reset),
    .clear   (to_clear),
    .tick    (to_tick),
    .expired (to_expired)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      fault_q   <= FLT_NONE;
      pc_q      <= RESET_VECTOR;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack)        state_d = DECODE;
        else if (to_expired) begin state_d = HALT; fault_d = FLT_FETCH_TO; end
      end
      DECODE: begin
        if (dec_illegal) begin state_d = HALT; fault_d = FLT_ILLEGAL; end
        else             state_d = EXECUTE;
      end
      EXECUTE: begin
        if (dec_is_load || dec_is_store) state_d = MEM;
        else if (dec_writes_rd)          state_d = WRITEBACK;
        else begin state_d = FETCH; retire = 1'b1; end
      end
      MEM: begin
        if (dmem_ack) begin
          if (dec_is_store) begin state_d = FETCH; retire = 1'b1; end
          else            state_d = WRITEBACK;
        end else if (to_expired) begin
          state_d = HALT; fault_d = FLT_DATA_TO;
        end
      end
      WRITEBACK: begin state_d = FETCH; retire = 1'b1; end
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase

    // decoder/ALU inputs are held by the IR, so they are still valid at retire
    redirect  = dec_is_jump || (dec_is_branch && branch_taken_in);
    pc_d      = pc_q;
    instret_d = instret_q;
    if (retire) begin
      pc_d      = redirect ? {target_in[XLEN-1:2], 2'b00} : pc_q + XLEN'(PC_STEP);
      instret_d = instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    halted_out   = 1'b0;
    case (state_q)
      FETCH:     begin imem_req = 1'b1; ir_write = imem_ack; end
      MEM:       begin dmem_req = 1'b1; dmem_we = dec_is_store; end
      WRITEBACK: reg_write_en = 1'b1;
      HALT:      halted_out = 1'b1;
      default:   ;
    endcase
  end

  assign imem_addr      = pc_q;
  assign pc_out         = pc_q;
  assign state_out      = state_q;
  assign instret_out    = instret_q;
  assign fault_code_out = fault_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed table, hand-written corner sequences, random vs. model.
module tb_multicycle_sequencer;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 16;
  localparam int unsigned CNTW = 4;
  localparam logic [31:0] RV   = 32'h100;

  logic clk_in = 1'b0, reset = 1'b1;
  logic imem_req, imem_ack, ir_write;
  logic [31:0] imem_addr, target_in, pc_out;
  logic dec_illegal, dec_is_load, dec_is_store, dec_writes_rd, dec_is_branch, dec_is_jump, branch_taken_in;
  logic dmem_req, dmem_we, dmem_ack, reg_write_en, halted_out;
  logic [2:0] state_out;
  logic [CNTW-1:0] instret_out;
  logic [1:0] fault_code_out;

  always #5 clk_in = ~clk_in;

  multicycle_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .MEM_TIMEOUT(TMO), .CNT_W(CNTW)) dut (
    .clk_in(clk_in), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .ir_write(ir_write),
    .dec_illegal(dec_illegal), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_writes_rd(dec_writes_rd), .dec_is_branch(dec_is_branch), .dec_is_jump(dec_is_jump),
    .branch_taken_in(branch_taken_in), .target_in(target_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .reg_write_en(reg_write_en),
    .pc_out(pc_out), .state_out(state_out), .instret_out(instret_out),
    .halted_out(halted_out), .fault_code_out(fault_code_out)
  );

  typedef struct {
    logic ld, st, wr, br, jp, tk, ill;
    logic [31:0] tgt;
    int iw, dw;
    int e_cyc;
    logic [31:0] e_pc;
    int e_ret;
    int e_flt;
  } vec_t;

  int checks = 0, errors = 0;
  logic [31:0] m_pc;
  int m_ret;
  vec_t tbl[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, st, wr, br, jp, tk, ill, input logic [31:0] tgt,
                              input int iw, dw, cyc, input logic [31:0] pc, input int ret, flt);
    vec_t v;
    v.ld = ld; v.st = st; v.wr = wr; v.br = br; v.jp = jp; v.tk = tk; v.ill = ill;
    v.tgt = tgt; v.iw = iw; v.dw = dw; v.e_cyc = cyc; v.e_pc = pc; v.e_ret = ret; v.e_flt = flt;
    return v;
  endfunction

  // Instruction-level reference: latency from stage counts plus waits, faults, PC and retire count.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int c;
    r.e_flt = 0;
    if (v.iw >= int'(TMO)) begin r.e_flt = 1; c = TMO; end
    else begin
      c = v.iw + 2;
      if (v.ill) r.e_flt = 2;
      else begin
        c += 1;
        if (v.ld || v.st) begin
          if (v.dw >= int'(TMO)) begin r.e_flt = 3; c += TMO; end
          else c += v.dw + 1 + (v.ld ? 1 : 0);
        end else if (v.wr) c += 1;
      end
    end
    if (r.e_flt == 0) begin
      m_pc  = (v.jp || (v.br && v.tk)) ? (v.tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
      m_ret = (m_ret + 1) % (1 << CNTW);
    end
    r.e_cyc = c; r.e_pc = m_pc; r.e_ret = m_ret;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    m_pc = RV; m_ret = 0;
  endtask

  // Acts as both memories for one instruction, starting at a negedge with the DUT in FETCH.
  task automatic apply(input vec_t v, input string tag);
    int cyc = 0, icnt = 0, dcnt = 0, rwe = 0, dreq = 0, irw = 0, webad = 0;
    bit left = 0;
    int e_rwe, e_dreq, e_irw;
    dec_is_load = v.ld; dec_is_store = v.st; dec_writes_rd = v.wr; dec_is_branch = v.br;
    dec_is_jump = v.jp; branch_taken_in = v.tk; dec_illegal = v.ill; target_in = v.tgt;
    while (1) begin
      if (cyc >= 150) begin chk({tag, "_budget"}, 64'(cyc), 64'(v.e_cyc)); break; end
      if (halted_out) break;
      if (imem_req && left) break;
      imem_ack = imem_req && (icnt == v.iw);
      dmem_ack = dmem_req && (dcnt == v.dw);
      #1;
      if (ir_write) irw++;
      if (imem_req) begin icnt++; if (imem_ack) left = 1; end
      if (dmem_req) begin dcnt++; dreq++; if (dmem_we !== v.st) webad++; end
      if (reg_write_en) rwe++;
      cyc++;
      @(negedge clk_in);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    e_irw  = (v.iw >= int'(TMO)) ? 0 : 1;
    e_dreq = (v.e_flt == 0 || v.e_flt == 3) && (v.ld || v.st) ? ((v.dw >= int'(TMO)) ? TMO : v.dw + 1) : 0;
    e_rwe  = (v.e_flt == 0) && (v.ld || (!v.st && v.wr)) ? 1 : 0;
    chk({tag, "_cycles"}, 64'(cyc), 64'(v.e_cyc));
    chk({tag, "_pc"}, 64'(pc_out), 64'(v.e_pc));
    chk({tag, "_instret"}, 64'(instret_out), 64'(v.e_ret));
    chk({tag, "_fault"}, 64'(fault_code_out), 64'(v.e_flt));
    chk({tag, "_halted"}, 64'(halted_out), 64'(v.e_flt != 0));
    chk({tag, "_rwe"}, 64'(rwe), 64'(e_rwe));
    chk({tag, "_dreq"}, 64'(dreq), 64'(e_dreq));
    chk({tag, "_irwrite"}, 64'(irw), 64'(e_irw));
    chk({tag, "_we_bad"}, 64'(webad), 64'(0));
  endtask

  initial begin
    imem_ack = 0; dmem_ack = 0; target_in = 0;
    dec_illegal = 0; dec_is_load = 0; dec_is_store = 0; dec_writes_rd = 0;
    dec_is_branch = 0; dec_is_jump = 0; branch_taken_in = 0;

    //              ld st wr br jp tk il  tgt           iw  dw  cyc  pc            ret flt
    tbl[0]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         0,  0,  4,  32'h104,       1,  0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         0,  0,  4,  32'h108,       2,  0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         0,  0,  4,  32'h10C,       3,  0);
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 0, 32'h0,         0,  3,  8,  32'h110,       4,  0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,         1,  0,  5,  32'h114,       5,  0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 1, 0, 32'h203,       0,  0,  3,  32'h200,       6,  0);
    tbl[6]  = mk(0, 0, 0, 1, 0, 0, 0, 32'h500,       0,  0,  3,  32'h204,       7,  0);
    tbl[7]  = mk(0, 0, 1, 0, 1, 0, 0, 32'hFFFFFFFF,  0,  0,  4,  32'hFFFFFFFC,  8,  0);
    tbl[8]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         0,  0,  4,  32'h0,         9,  0);
    tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,         15, 0,  19, 32'h4,         10, 0);
    tbl[10] = mk(1, 0, 1, 0, 0, 0, 0, 32'h0,         0,  15, 20, 32'h8,         11, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0,  0,  3,  32'hC,         12, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0,  0,  3,  32'h10,        13, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0,  0,  3,  32'h14,        14, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0,  0,  3,  32'h18,        15, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,         0,  0,  3,  32'h1C,        0,  0);
    tbl[16] = mk(0, 0, 1, 0, 0, 0, 1, 32'h0,         0,  0,  2,  32'h1C,        0,  2);

    do_reset();
    #1;
    chk("rst_state", 64'(state_out), 64'(0));
    chk("rst_pc", 64'(pc_out), 64'(RV));
    chk("rst_addr", 64'(imem_addr), 64'(RV));
    chk("rst_instret", 64'(instret_out), 64'(0));
    chk("rst_halted", 64'(halted_out), 64'(0));
    chk("rst_fault", 64'(fault_code_out), 64'(0));
    chk("rst_imem_req", 64'(imem_req), 64'(1));
    chk("rst_dmem_req", 64'(dmem_req), 64'(0));
    chk("rst_rwe", 64'(reg_write_en), 64'(0));

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("vec%0d", i));
    chk("ill_state", 64'(state_out), 64'(5));

    // Fetch timeout, then acks and a fake data ack must be ignored while halted.
    do_reset();
    apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 16, 0, 16, RV, 0, 1), "fetch_to");
    for (int k = 0; k < 3; k++) begin
      imem_ack = 1'b1; dmem_ack = 1'b1; #1;
      chk($sformatf("halt_irw%0d", k), 64'(ir_write), 64'(0));
      chk($sformatf("halt_ireq%0d", k), 64'(imem_req), 64'(0));
      @(negedge clk_in);
      chk($sformatf("halt_state%0d", k), 64'(state_out), 64'(5));
      chk($sformatf("halt_pc%0d", k), 64'(pc_out), 64'(RV));
      chk($sformatf("halt_fault%0d", k), 64'(fault_code_out), 64'(1));
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;

    do_reset();
    apply(model(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 16, 0, 0, 0, 0)), "data_to");

    // Reset asserted while a load waits in MEM.
    do_reset();
    dec_illegal = 0; dec_is_load = 1; dec_is_store = 0; dec_writes_rd = 1;
    dec_is_branch = 0; dec_is_jump = 0;
    imem_ack = 1'b1; @(negedge clk_in); imem_ack = 1'b0;
    begin
      int n = 0;
      while (!dmem_req && n < 20) begin @(negedge clk_in); n++; end
      chk("mid_mem_reached", 64'(dmem_req), 64'(1));
    end
    @(negedge clk_in);
    reset = 1'b1; #1;
    chk("mid_rst_state", 64'(state_out), 64'(0));
    chk("mid_rst_pc", 64'(pc_out), 64'(RV));
    chk("mid_rst_dreq", 64'(dmem_req), 64'(0));
    @(negedge clk_in);
    reset = 1'b0; m_pc = RV; m_ret = 0;

    // Random instruction stream against the model.
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      int kind = $urandom_range(0, 4);
      int r;
      v = mk(0, 0, 0, 0, 0, 0, 0, $urandom, 0, 0, 0, 0, 0, 0);
      case (kind)
        0: v.wr = 1;
        1: begin v.ld = 1; v.wr = 1; end
        2: v.st = 1;
        3: begin v.br = 1; v.tk = 1'($urandom_range(0, 1)); end
        default: begin v.jp = 1; v.wr = 1'($urandom_range(0, 1)); end
      endcase
      v.ill = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 19);
      v.iw = (r < 16) ? r % 4 : (r == 19 ? 16 : 15);
      r = $urandom_range(0, 19);
      v.dw = (r < 16) ? r % 4 : (r == 19 ? 16 : 15);
      v = model(v);
      apply(v, $sformatf("rnd%0d", i));
      if (v.e_flt != 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
